text_stream_feeder: RTL

//  Converts a byte stream of character codes into text-RAM writes for the

---
 rtl/text_stream_feeder.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/text_stream_feeder.sv
// Turns a character-code byte stream into text-RAM writes, with cursor tracking, scroll by row-base rotation and clears.
// Optional TEXT_FEEDER_TAB_EN: code 8'h09 jumps to the next multiple-of-8 column instead of being printed.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accepting codes; printable/newline/backspace handled inline
// CLR_ROW | blanking the line that just became the bottom line (scroll)
// CLR_ALL | blanking the whole RAM row-major, then homing cursor/base
module text_stream_feeder #(
    parameter int                ROWS       = 15,
    parameter int                COLS       = 40,
    parameter int                ROW_W      = 4,
    parameter int                COL_W      = 6,
    parameter int                CHAR_W     = 8,
    parameter logic [CHAR_W-1:0] CLEAR_CODE = 8'hFF,
    parameter logic [CHAR_W-1:0] NL_CODE    = 8'h0A,
    parameter logic [CHAR_W-1:0] BS_CODE    = 8'h08,
    parameter logic [CHAR_W-1:0] BLANK_CODE = 8'h20
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CHAR_W-1:0] in_char_i,
    output logic              wr_en_o,
    output logic [ROW_W-1:0]  wr_row_o,
    output logic [COL_W-1:0]  wr_col_o,
    output logic [CHAR_W-1:0] wr_char_o,
    output logic [ROW_W-1:0]  row_base_o,
    output logic [ROW_W-1:0]  cursor_row_o,
    output logic [COL_W-1:0]  cursor_col_o,
    output logic              push_up_o,
    output logic              clear_done_o
);

    localparam int                CNT_W     = ROW_W + COL_W;
    localparam int                SUM_W     = ROW_W + 1;
    localparam logic [CNT_W-1:0]  ALL_CELLS = CNT_W'(ROWS * COLS);
    localparam logic [CNT_W-1:0]  ROW_CELLS = CNT_W'(COLS);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);

`ifdef TEXT_FEEDER_TAB_EN
    localparam logic [CHAR_W-1:0] TAB_CODE  = CHAR_W'(9);
`endif

    typedef enum logic [1:0] {
        IDLE,
        CLR_ROW,
        CLR_ALL
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               wr_en_q, wr_en_d;
    logic [ROW_W-1:0]   wr_row_q, wr_row_d;
    logic [COL_W-1:0]   wr_col_q, wr_col_d;
    logic [CHAR_W-1:0]  wr_char_q, wr_char_d;
    logic [ROW_W-1:0]   row_base_q, row_base_d;
    logic [ROW_W-1:0]   cur_row_q, cur_row_d;
    logic [COL_W-1:0]   cur_col_q, cur_col_d;
    logic               push_up_q, push_up_d;
    logic               clear_done_q, clear_done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   clr_row_q, clr_row_d;
    logic [COL_W-1:0]   clr_col_q, clr_col_d;
    logic               do_nl;
`ifdef TEXT_FEEDER_TAB_EN
    logic [COL_W:0]     tab_next;
`endif

    // Logical row to physical RAM row: (row + base) mod ROWS without relying on overflow.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] row,
                                                  input logic [ROW_W-1:0] base);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, row} + {1'b0, base};
        if (sum >= SUM_W'(ROWS)) begin
            sum = sum - SUM_W'(ROWS);
        end
        return sum[ROW_W-1:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        wr_en_d      = 1'b0;
        wr_row_d     = wr_row_q;
        wr_col_d     = wr_col_q;
        wr_char_d    = wr_char_q;
        row_base_d   = row_base_q;
        cur_row_d    = cur_row_q;
        cur_col_d    = cur_col_q;
        push_up_d    = 1'b0;
        clear_done_d = 1'b0;
        cnt_d        = cnt_q;
        clr_row_d    = clr_row_q;
        clr_col_d    = clr_col_q;
        do_nl        = 1'b0;
`ifdef TEXT_FEEDER_TAB_EN
        tab_next     = '0;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    if (in_char_i == CLEAR_CODE) begin
                        state_d   = CLR_ALL;
                        cnt_d     = ALL_CELLS;
                        clr_row_d = '0;
                        clr_col_d = '0;
                    end else if (in_char_i == NL_CODE) begin
                        do_nl = 1'b1;
                    end else if (in_char_i == BS_CODE) begin
                        if (cur_col_q != '0) begin
                            cur_col_d = cur_col_q - COL_W'(1);
                            wr_en_d   = 1'b1;
                            wr_row_d  = phys_row(cur_row_q, row_base_q);
                            wr_col_d  = cur_col_q - COL_W'(1);
                            wr_char_d = BLANK_CODE;
                        end else if (cur_row_q != '0) begin
                            cur_row_d = cur_row_q - ROW_W'(1);
                            cur_col_d = LAST_COL;
                            wr_en_d   = 1'b1;
                            wr_row_d  = phys_row(cur_row_q - ROW_W'(1), row_base_q);
                            wr_col_d  = LAST_COL;
                            wr_char_d = BLANK_CODE;
                        end
`ifdef TEXT_FEEDER_TAB_EN
                    end else if (in_char_i == TAB_CODE) begin
                        tab_next = {1'b0, cur_col_q[COL_W-1:3], 3'b000} + (COL_W+1)'(8);
                        if (tab_next >= (COL_W+1)'(COLS)) begin
                            do_nl = 1'b1;
                        end else begin
                            cur_col_d = tab_next[COL_W-1:0];
                        end
`endif
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_row_d  = phys_row(cur_row_q, row_base_q);
                        wr_col_d  = cur_col_q;
                        wr_char_d = in_char_i;
                        if (cur_col_q == LAST_COL) begin
                            do_nl = 1'b1;
                        end else begin
                            cur_col_d = cur_col_q + COL_W'(1);
                        end
                    end

                    // Scrolling rotates the base; the old top line becomes the new bottom and is blanked.
                    if (do_nl) begin
                        cur_col_d = '0;
                        if (cur_row_q < LAST_ROW) begin
                            cur_row_d = cur_row_q + ROW_W'(1);
                        end else begin
                            row_base_d = (row_base_q == LAST_ROW) ? '0 : row_base_q + ROW_W'(1);
                            push_up_d  = 1'b1;
                            state_d    = CLR_ROW;
                            cnt_d      = ROW_CELLS;
                            clr_row_d  = row_base_q;
                            clr_col_d  = '0;
                        end
                    end
                end
            end

            CLR_ROW: begin
                wr_en_d   = 1'b1;
                wr_row_d  = clr_row_q;
                wr_col_d  = clr_col_q;
                wr_char_d = BLANK_CODE;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    clr_col_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_col_d = clr_col_q + COL_W'(1);
                end
            end

            CLR_ALL: begin
                if (cnt_q != '0) begin
                    wr_en_d   = 1'b1;
                    wr_row_d  = clr_row_q;
                    wr_col_d  = clr_col_q;
                    wr_char_d = BLANK_CODE;
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (clr_col_q == LAST_COL) begin
                        clr_col_d = '0;
                        clr_row_d = (clr_row_q == LAST_ROW) ? '0 : clr_row_q + ROW_W'(1);
                    end else begin
                        clr_col_d = clr_col_q + COL_W'(1);
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        row_base_d = '0;
                        cur_row_d  = '0;
                        cur_col_d  = '0;
                    end
                end else begin
                    clear_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_row_q     <= '0;
            wr_col_q     <= '0;
            wr_char_q    <= '0;
            row_base_q   <= '0;
            cur_row_q    <= '0;
            cur_col_q    <= '0;
            push_up_q    <= 1'b0;
            clear_done_q <= 1'b0;
            cnt_q        <= '0;
            clr_row_q    <= '0;
            clr_col_q    <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_row_q     <= wr_row_d;
            wr_col_q     <= wr_col_d;
            wr_char_q    <= wr_char_d;
            row_base_q   <= row_base_d;
            cur_row_q    <= cur_row_d;
            cur_col_q    <= cur_col_d;
            push_up_q    <= push_up_d;
            clear_done_q <= clear_done_d;
            cnt_q        <= cnt_d;
            clr_row_q    <= clr_row_d;
            clr_col_q    <= clr_col_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign wr_en_o      = wr_en_q;
    assign wr_row_o     = wr_row_q;
    assign wr_col_o     = wr_col_q;
    assign wr_char_o    = wr_char_q;
    assign row_base_o   = row_base_q;
    assign cursor_row_o = cur_row_q;
    assign cursor_col_o = cur_col_q;
    assign push_up_o    = push_up_q;
    assign clear_done_o = clear_done_q;

endmodule
